// File: rtl/debug_ctrl_pkg.sv
// Shared state encodings and UART command bytes for the pipeline debug controller.
package debug_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_STEP_WAIT,
    ST_STEP_EXEC,
    ST_DUMP_ADDR,
    ST_DUMP_WAIT,
    ST_DUMP_SEND
  } state_t;

  typedef enum logic [1:0] {
    PH_PC,
    PH_REG,
    PH_MEM,
    PH_CNT
  } dump_phase_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;
  localparam logic [7:0] CMD_QUIT = 8'h51;

  localparam int unsigned IDX_W  = 16;
  localparam int unsigned WAIT_W = 8;

  function automatic logic is_dump(input state_t s);
    return (s == ST_DUMP_ADDR) || (s == ST_DUMP_WAIT) || (s == ST_DUMP_SEND);
  endfunction

endpackage

// File: rtl/word_tx_serializer.sv
// Sends one loaded word as bytes MSB-first over a valid/ready handshake, pulsing done after the last byte.
module word_tx_serializer #(
  parameter int unsigned NB_DATA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [NB_DATA-1:0] word,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic               done
);

  localparam int unsigned N_BYTES = NB_DATA / 8;
  localparam int unsigned CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic [NB_DATA-1:0] word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tx_valid_q, tx_valid_d;
  logic               done_q, done_d;

  always_comb begin
    word_d     = word_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    if (load) begin
      word_d     = word;
      cnt_d      = '0;
      tx_valid_d = 1'b1;
    end else if (tx_valid_q && tx_ready) begin
      if (cnt_q == CNT_W'(N_BYTES - 1)) begin
        tx_valid_d = 1'b0;
        done_d     = 1'b1;
      end else begin
        cnt_d  = CNT_W'(cnt_q + 1'b1);
        word_d = {word_q[NB_DATA-9:0], 8'h00};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_q     <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  // Current byte is always the top of the shifting word register.
  assign tx_data  = word_q[NB_DATA-1 -: 8];
  assign tx_valid = tx_valid_q;
  assign done     = done_q;

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// UART-driven loader / run / single-step / state-dump controller for the MIPS pipeline.
// Optional DEBUG_CYCLE_COUNT_EN appends an enabled-cycle counter word to every dump.
module pipeline_debug_ctrl
  import debug_ctrl_pkg::*;
#(
  parameter int unsigned        NB_DATA    = 32,
  parameter int unsigned        NB_REG     = 5,
  parameter int unsigned        N_REGISTER = 32,
  parameter int unsigned        NB_ADDR    = 7,
  parameter int unsigned        N_MEM_DUMP = 32,
  parameter int unsigned        IMEM_WORDS = 256,
  parameter int unsigned        ADDR_STEP  = 4,
  parameter logic [NB_DATA-1:0] HALT_INSTR = '1,
  parameter int unsigned        READ_LAT   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               en_pipeline,
  output logic               en_read_inst,
  output logic [NB_DATA-1:0] data_inst_to_write,
  output logic               ready_instr_to_write,
  output logic [NB_DATA-1:0] o_dir_mem_write,
  output logic               select_debug_or_wireA,
  output logic [NB_REG-1:0]  addr_reg_debug,
  output logic               select_debug_or_alu_result,
  output logic [NB_ADDR-1:0] addr_mem_debug,
  input  logic [NB_DATA-1:0] data_registers_debug,
  input  logic [NB_DATA-1:0] data_mem_debug,
  input  logic [NB_DATA-1:0] data_pc_debug,
  input  logic               halt_signal_o_wb
);

  localparam logic [NB_DATA-1:0] LAST_ADDR = NB_DATA'((IMEM_WORDS - 1) * ADDR_STEP);
  localparam logic [IDX_W-1:0]   REG_LAST  = IDX_W'(N_REGISTER - 1);
  localparam logic [IDX_W-1:0]   MEM_LAST  = IDX_W'(N_MEM_DUMP - 1);

  state_t             state_q, state_d, dump_exit_c;
  dump_phase_t        phase_q, phase_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [NB_DATA-1:0] addr_q, addr_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [NB_DATA-9:0] sh_q, sh_d;
  logic               step_mode_q, step_mode_d;
  logic               halt_seen_q, halt_seen_d;
  logic               ready_q, ready_d;
  logic [NB_DATA-1:0] data_inst_q, data_inst_d;
  logic [NB_DATA-1:0] dir_q, dir_d;
  logic               en_q, en_d;
  logic               sel_q, sel_d;
  logic [NB_REG-1:0]  areg_q, areg_d;
  logic [NB_ADDR-1:0] amem_q, amem_d;
  logic [NB_DATA-1:0] word_c, cap_c, cyc_word_c;
  logic               ser_load_c, ser_done;

  assign word_c = {sh_q, rx_data};

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    bcnt_d      = bcnt_q;
    sh_d        = sh_q;
    step_mode_d = step_mode_q;
    halt_seen_d = halt_seen_q;
    ready_d     = 1'b0;
    data_inst_d = data_inst_q;
    dir_d       = dir_q;
    ser_load_c  = 1'b0;

    // A halt reaching WB during a step or its dump ends single-step mode afterwards.
    if (step_mode_q && halt_signal_o_wb && (state_q == ST_STEP_EXEC || is_dump(state_q)))
      halt_seen_d = 1'b1;
    dump_exit_c = (step_mode_q && !halt_seen_d) ? ST_STEP_WAIT : ST_IDLE;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_LOAD: begin state_d = ST_LOAD; bcnt_d = '0; addr_d = '0; end
            CMD_RUN:  begin state_d = ST_RUN; step_mode_d = 1'b0; end
            CMD_STEP: begin state_d = ST_STEP_WAIT; step_mode_d = 1'b1; halt_seen_d = 1'b0; end
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (rx_valid) begin
          sh_d   = word_c[NB_DATA-9:0];
          bcnt_d = 2'(bcnt_q + 2'd1);
          if (bcnt_q == 2'd3) begin
            ready_d     = 1'b1;
            data_inst_d = word_c;
            dir_d       = addr_q;
            if (word_c == HALT_INSTR || addr_q == LAST_ADDR) begin
              state_d = ST_IDLE;
              addr_d  = '0;
            end else begin
              addr_d = addr_q + NB_DATA'(ADDR_STEP);
            end
          end
        end
      end
      ST_RUN: begin
        if (halt_signal_o_wb) begin
          state_d = ST_DUMP_ADDR;
          phase_d = PH_PC;
          idx_d   = '0;
        end
      end
      ST_STEP_WAIT: begin
        if (rx_valid && rx_data == CMD_NEXT) state_d = ST_STEP_EXEC;
        else if (rx_valid && rx_data == CMD_QUIT) state_d = ST_IDLE;
      end
      ST_STEP_EXEC: begin
        state_d = ST_DUMP_ADDR;
        phase_d = PH_PC;
        idx_d   = '0;
      end
      ST_DUMP_ADDR: begin
        state_d = ST_DUMP_WAIT;
        wait_d  = '0;
      end
      ST_DUMP_WAIT: begin
        if (wait_q == WAIT_W'(READ_LAT - 1)) begin
          ser_load_c = 1'b1;
          state_d    = ST_DUMP_SEND;
        end else begin
          wait_d = WAIT_W'(wait_q + 1'b1);
        end
      end
      ST_DUMP_SEND: begin
        if (ser_done) begin
          state_d = ST_DUMP_ADDR;
          idx_d   = IDX_W'(idx_q + 1'b1);
          case (phase_q)
            PH_PC:  begin phase_d = PH_REG; idx_d = '0; end
            PH_REG: if (idx_q == REG_LAST) begin phase_d = PH_MEM; idx_d = '0; end
            PH_MEM: if (idx_q == MEM_LAST) begin
`ifdef DEBUG_CYCLE_COUNT_EN
              phase_d = PH_CNT;
              idx_d   = '0;
`else
              state_d = dump_exit_c;
`endif
            end
            default: state_d = dump_exit_c;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the next state so they are registered yet aligned with it.
    en_d   = (state_d == ST_RUN) || (state_d == ST_STEP_EXEC);
    sel_d  = is_dump(state_d);
    areg_d = sel_d ? NB_REG'(idx_d) : '0;
    amem_d = sel_d ? NB_ADDR'(idx_d) : '0;
  end

  always_comb begin
    case (phase_q)
      PH_PC:   cap_c = data_pc_debug;
      PH_REG:  cap_c = data_registers_debug;
      PH_MEM:  cap_c = data_mem_debug;
      default: cap_c = cyc_word_c;
    endcase
  end

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == ST_IDLE && (state_d == ST_RUN || state_d == ST_STEP_WAIT)) cyc_d = '0;
    else if (en_q) cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign cyc_word_c = NB_DATA'(cyc_q);
`else
  assign cyc_word_c = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_PC;
      idx_q       <= '0;
      wait_q      <= '0;
      addr_q      <= '0;
      bcnt_q      <= '0;
      sh_q        <= '0;
      step_mode_q <= 1'b0;
      halt_seen_q <= 1'b0;
      ready_q     <= 1'b0;
      data_inst_q <= '0;
      dir_q       <= '0;
      en_q        <= 1'b0;
      sel_q       <= 1'b0;
      areg_q      <= '0;
      amem_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      bcnt_q      <= bcnt_d;
      sh_q        <= sh_d;
      step_mode_q <= step_mode_d;
      halt_seen_q <= halt_seen_d;
      ready_q     <= ready_d;
      data_inst_q <= data_inst_d;
      dir_q       <= dir_d;
      en_q        <= en_d;
      sel_q       <= sel_d;
      areg_q      <= areg_d;
      amem_q      <= amem_d;
    end
  end

  word_tx_serializer #(.NB_DATA(NB_DATA)) u_ser (
    .clock    (clock),
    .reset    (reset),
    .load     (ser_load_c),
    .word     (cap_c),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (ser_done)
  );

  assign en_pipeline                = en_q;
  assign en_read_inst               = en_q;
  assign data_inst_to_write         = data_inst_q;
  assign ready_instr_to_write       = ready_q;
  assign o_dir_mem_write            = dir_q;
  assign select_debug_or_wireA      = sel_q;
  assign addr_reg_debug             = areg_q;
  assign select_debug_or_alu_result = sel_q;
  assign addr_mem_debug             = amem_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed + randomized bench for pipeline_debug_ctrl with a byte-stream reference model.
module tb_pipeline_debug_ctrl;
  import debug_ctrl_pkg::*;

  localparam int unsigned NB_DATA    = 32;
  localparam int unsigned NB_REG     = 5;
  localparam int unsigned N_REGISTER = 32;
  localparam int unsigned NB_ADDR    = 7;
  localparam int unsigned N_MEM_DUMP = 32;
  localparam int unsigned IMEM_WORDS = 256;
  localparam int unsigned ADDR_STEP  = 4;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif
  localparam int DUMP_BYTES = 4 * (1 + N_REGISTER + N_MEM_DUMP) + (HAS_CNT ? 4 : 0);

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_valid = 1'b0;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready = 1'b0;
  logic               en_pipeline, en_read_inst;
  logic [NB_DATA-1:0] data_inst_to_write, o_dir_mem_write;
  logic               ready_instr_to_write;
  logic               select_debug_or_wireA, select_debug_or_alu_result;
  logic [NB_REG-1:0]  addr_reg_debug;
  logic [NB_ADDR-1:0] addr_mem_debug;
  logic [NB_DATA-1:0] data_registers_debug = '0;
  logic [NB_DATA-1:0] data_mem_debug = '0;
  logic [NB_DATA-1:0] data_pc_debug = '0;
  logic               halt_signal_o_wb = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] regs [N_REGISTER];
  logic [31:0] mem  [2**NB_ADDR];
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  logic [63:0] wr_q[$];
  int          en_cycles = 0;
  int          tx_viol = 0;
  int          en_viol = 0;
  bit          stall = 1'b0;
  bit          hold_pend = 1'b0;
  logic [7:0]  hold_data = 8'h00;

  always #5 clock = ~clock;

  pipeline_debug_ctrl dut (
    .clock                      (clock),
    .reset                      (reset),
    .rx_data                    (rx_data),
    .rx_valid                   (rx_valid),
    .tx_data                    (tx_data),
    .tx_valid                   (tx_valid),
    .tx_ready                   (tx_ready),
    .en_pipeline                (en_pipeline),
    .en_read_inst               (en_read_inst),
    .data_inst_to_write         (data_inst_to_write),
    .ready_instr_to_write       (ready_instr_to_write),
    .o_dir_mem_write            (o_dir_mem_write),
    .select_debug_or_wireA      (select_debug_or_wireA),
    .addr_reg_debug             (addr_reg_debug),
    .select_debug_or_alu_result (select_debug_or_alu_result),
    .addr_mem_debug             (addr_mem_debug),
    .data_registers_debug       (data_registers_debug),
    .data_mem_debug             (data_mem_debug),
    .data_pc_debug              (data_pc_debug),
    .halt_signal_o_wb           (halt_signal_o_wb)
  );

  // Register file and data memory with one cycle of read latency.
  always @(posedge clock) begin
    data_registers_debug <= regs[addr_reg_debug];
    data_mem_debug       <= mem[addr_mem_debug];
  end

  // Drives tx_ready, collects accepted bytes and write strobes, watches per-cycle rules.
  always @(negedge clock) begin
    tx_ready = stall ? 1'b0 : ($urandom_range(3) != 0);
    if (hold_pend && (tx_valid !== 1'b1 || tx_data !== hold_data)) tx_viol++;
    hold_pend = tx_valid && !tx_ready;
    hold_data = tx_data;
    if (tx_valid && tx_ready) got.push_back(tx_data);
    if (ready_instr_to_write) wr_q.push_back({o_dir_mem_write, data_inst_to_write});
    if (en_pipeline) en_cycles++;
    if (en_read_inst !== en_pipeline) en_viol++;
    if (en_pipeline && (ready_instr_to_write || select_debug_or_wireA || select_debug_or_alu_result))
      en_viol++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic randomize_state();
    for (int i = 0; i < int'(N_REGISTER); i++) regs[i] = $urandom;
    for (int i = 0; i < 2**NB_ADDR; i++) mem[i] = $urandom;
    data_pc_debug = $urandom;
  endtask

  // Expected dump: PC, all registers, first N_MEM_DUMP memory words, optional cycle count.
  task automatic expect_dump(input string tag, input int base, input logic [31:0] cyc);
    int n;
    int bad;
    exp_q.delete();
    push_word(data_pc_debug);
    for (int i = 0; i < int'(N_REGISTER); i++) push_word(regs[i]);
    for (int i = 0; i < int'(N_MEM_DUMP); i++) push_word(mem[i]);
    if (HAS_CNT) push_word(cyc);
    n = 0;
    while (got.size() - base < DUMP_BYTES && n < 20000) begin tick(); n++; end
    repeat (8) tick();
    check({tag, "_len"}, 64'(got.size() - base), 64'(DUMP_BYTES));
    bad = 0;
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
      if (got[base + i] !== exp_q[i]) bad++;
    check({tag, "_bytes"}, 64'(bad), 64'd0);
    check({tag, "_sel_off"}, 64'({select_debug_or_wireA, select_debug_or_alu_result}), 64'd0);
  endtask

  initial begin
    int wb, gb, be, n, bad, stable_bad;
    logic [31:0] words [IMEM_WORDS];
    logic [7:0]  sd;
    randomize_state();

    // Reset state
    repeat (3) tick();
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_en", 64'({en_pipeline, en_read_inst}), 64'd0);
    check("rst_wr", 64'({ready_instr_to_write, o_dir_mem_write, data_inst_to_write}), 64'd0);
    check("rst_sel", 64'({select_debug_or_wireA, select_debug_or_alu_result,
                          addr_reg_debug, addr_mem_debug}), 64'd0);
    reset = 1'b1;
    tick();

    // Short load terminated by the halt word
    wb = wr_q.size();
    send_byte(CMD_LOAD);
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFF);
    repeat (3) tick();
    check("load2_count", 64'(wr_q.size() - wb), 64'd2);
    check("load2_w0", wr_q[wb], {32'd0, 32'h0000_0001});
    check("load2_w1", wr_q[wb + 1], {32'd4, 32'hFFFF_FFFF});

    // Reset in the middle of a word aborts the partial word
    send_byte(CMD_LOAD);
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick();
    reset = 1'b0;
    #1;
    check("midrst_outs", 64'({ready_instr_to_write, en_pipeline, tx_valid,
                              select_debug_or_wireA, select_debug_or_alu_result}), 64'd0);
    check("midrst_dir", 64'(o_dir_mem_write), 64'd0);
    check("midrst_data", 64'(data_inst_to_write), 64'd0);
    tick();
    reset = 1'b1;
    wb = wr_q.size();
    send_byte(CMD_LOAD);
    send_word(32'h1122_3344);
    send_word(32'hFFFF_FFFF);
    repeat (3) tick();
    check("postrst_count", 64'(wr_q.size() - wb), 64'd2);
    check("postrst_w0", wr_q[wb], {32'd0, 32'h1122_3344});

    // Full instruction memory with no terminator
    wb = wr_q.size();
    send_byte(CMD_LOAD);
    for (int i = 0; i < int'(IMEM_WORDS); i++) begin
      words[i] = $urandom;
      if (words[i] == 32'hFFFF_FFFF) words[i] = 32'h0;
      send_word(words[i]);
    end
    repeat (3) tick();
    check("full_count", 64'(wr_q.size() - wb), 64'(IMEM_WORDS));
    bad = 0;
    for (int i = 0; i < int'(IMEM_WORDS) && wb + i < wr_q.size(); i++)
      if (wr_q[wb + i] !== {32'(i * ADDR_STEP), words[i]}) bad++;
    check("full_words", 64'(bad), 64'd0);
    check("full_last_addr", 64'(wr_q[wb + IMEM_WORDS - 1][63:32]), 64'((IMEM_WORDS - 1) * ADDR_STEP));
    wb = wr_q.size();
    send_byte(CMD_LOAD);
    send_word(32'h0000_0005);
    send_word(32'hFFFF_FFFF);
    repeat (3) tick();
    check("after_full_w0", wr_q[wb], {32'd0, 32'h0000_0005});

    // Continuous run, halt reaching WB on the tenth enabled cycle
    randomize_state();
    be = en_cycles;
    gb = got.size();
    send_byte(CMD_RUN);
    n = 0;
    while (en_cycles - be < 10 && n < 200) begin tick(); n++; end
    halt_signal_o_wb = 1'b1;
    tick();
    check("run_en_drop", 64'({en_pipeline, en_read_inst}), 64'd0);
    expect_dump("run", gb, 32'd10);
    check("run_en_cycles", 64'(en_cycles - be), 64'd10);
    halt_signal_o_wb = 1'b0;

    // Single steps
    be = en_cycles;
    send_byte(CMD_STEP);
    randomize_state();
    gb = got.size();
    send_byte(CMD_NEXT);
    expect_dump("step1", gb, 32'd1);
    check("step1_en", 64'(en_cycles - be), 64'd1);
    randomize_state();
    gb = got.size();
    send_byte(CMD_NEXT);
    expect_dump("step2", gb, 32'd2);
    check("step2_en", 64'(en_cycles - be), 64'd2);
    send_byte(CMD_QUIT);
    be = en_cycles;
    gb = got.size();
    send_byte(CMD_NEXT);
    repeat (10) tick();
    check("quit_no_step", 64'(en_cycles - be), 64'd0);
    check("quit_no_tx", 64'(got.size() - gb), 64'd0);

    // Step that retires the halt instruction leaves step mode
    be = en_cycles;
    send_byte(CMD_STEP);
    randomize_state();
    halt_signal_o_wb = 1'b1;
    gb = got.size();
    send_byte(CMD_NEXT);
    expect_dump("stephalt", gb, 32'd1);
    halt_signal_o_wb = 1'b0;
    send_byte(CMD_NEXT);
    repeat (10) tick();
    check("stephalt_idle", 64'(en_cycles - be), 64'd1);

    // Back-pressure mid-dump with a stray rx byte; halt already high gives one run cycle
    randomize_state();
    halt_signal_o_wb = 1'b1;
    be = en_cycles;
    gb = got.size();
    send_byte(CMD_RUN);
    n = 0;
    while (got.size() - gb < 40 && n < 2000) begin tick(); n++; end
    stall = 1'b1;
    tick();
    n = 0;
    while (tx_valid !== 1'b1 && n < 50) begin tick(); n++; end
    sd = tx_data;
    n = got.size();
    stable_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        rx_data = CMD_LOAD;
        rx_valid = 1'b1;
      end else rx_valid = 1'b0;
      tick();
      if (tx_valid !== 1'b1 || tx_data !== sd) stable_bad++;
    end
    rx_valid = 1'b0;
    check("stall_stable", 64'(stable_bad), 64'd0);
    check("stall_no_accept", 64'(got.size() - n), 64'd0);
    stall = 1'b0;
    expect_dump("stall", gb, 32'd1);
    check("stall_run_cycles", 64'(en_cycles - be), 64'd1);
    halt_signal_o_wb = 1'b0;
    wb = wr_q.size();
    send_word(32'h0000_0007);
    repeat (3) tick();
    check("stray_rx_ignored", 64'(wr_q.size() - wb), 64'd0);

    check("tx_hold_rule", 64'(tx_viol), 64'd0);
    check("en_exclusive_rule", 64'(en_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
